// File: rtl/fifo_read_serializer_pkg.sv
// Constants and types shared by the SRAM FIFO and its read-side serializer.
package fifo_pkg;

    localparam int LANE_W     = 72;
    localparam int LANES      = 4;
    localparam int WORD_W     = LANE_W * LANES;
    localparam int LANE_IDX_W = 2;
    localparam int RD_LAT_DEF = 1;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [LANE_W-1:0]     lane_t;
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    // Number of reads in flight; the pending register is at most 3 deep.
    function automatic logic [1:0] pend_count(input logic [2:0] pend);
        return {1'b0, pend[0]} + {1'b0, pend[1]} + {1'b0, pend[2]};
    endfunction

endpackage

// File: rtl/fifo_read_serializer_if.sv
// FIFO read port plus the 72-bit lane stream, as seen by the serializer (master).
interface fifo_read_serializer_if;
    import fifo_pkg::*;

    logic      fifo_empty;
    logic      fifo_read_en;
    word_t     fifo_read_dt;
    logic      out_valid;
    logic      out_ready;
    lane_t     out_data;
    lane_idx_t out_lane;
    logic      out_last;
    logic      busy;

    modport master (
        input  fifo_empty, fifo_read_dt, out_ready,
        output fifo_read_en, out_valid, out_data, out_lane, out_last, busy
    );

    modport slave (
        output fifo_empty, fifo_read_dt, out_ready,
        input  fifo_read_en, out_valid, out_data, out_lane, out_last, busy
    );

endinterface

// File: rtl/fifo_read_serializer_word_buf2.sv
// Two-entry word buffer: cur is the word being serialized, nxt is its successor.
module word_buf2
    import fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  cap_i,
    input  word_t cap_word_i,
    input  logic  pop_i,
    output logic  cur_valid_o,
    output word_t cur_word_o,
    output logic  nxt_valid_o
);

    logic  cur_valid_q, cur_valid_d;
    logic  nxt_valid_q, nxt_valid_d;
    word_t cur_word_q,  cur_word_d;
    word_t nxt_word_q,  nxt_word_d;

    // Next-state: a pop frees cur before an arriving word is placed.
    always_comb begin
        cur_valid_d = cur_valid_q;
        nxt_valid_d = nxt_valid_q;
        cur_word_d  = cur_word_q;
        nxt_word_d  = nxt_word_q;
        if (pop_i) begin
            if (nxt_valid_q) begin
                cur_valid_d = 1'b1;
                cur_word_d  = nxt_word_q;
                nxt_valid_d = cap_i;
                nxt_word_d  = cap_i ? cap_word_i : nxt_word_q;
            end else if (cap_i) begin
                cur_valid_d = 1'b1;
                cur_word_d  = cap_word_i;
            end else begin
                cur_valid_d = 1'b0;
            end
        end else if (cap_i) begin
            if (!cur_valid_q) begin
                cur_valid_d = 1'b1;
                cur_word_d  = cap_word_i;
            end else begin
                nxt_valid_d = 1'b1;
                nxt_word_d  = cap_word_i;
            end
        end else begin
            cur_valid_d = cur_valid_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_valid_q <= 1'b0;
            nxt_valid_q <= 1'b0;
            cur_word_q  <= '0;
            nxt_word_q  <= '0;
        end else begin
            cur_valid_q <= cur_valid_d;
            nxt_valid_q <= nxt_valid_d;
            cur_word_q  <= cur_word_d;
            nxt_word_q  <= nxt_word_d;
        end
    end

    assign cur_valid_o = cur_valid_q;
    assign cur_word_o  = cur_word_q;
    assign nxt_valid_o = nxt_valid_q;

endmodule

// File: rtl/fifo_read_serializer.sv
// Pops 288-bit words from the SRAM FIFO and streams them out as four 72-bit lanes.
module fifo_read_serializer
    import fifo_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_read_serializer_if.master bus
);

    lane_idx_t         lane_q, lane_d;
    logic [RD_LAT-1:0] rd_pend_q;
    logic [RD_LAT-1:0] rd_pend_d;
    logic [RD_LAT:0]   pend_shift_s;
    logic              cur_valid_s;
    logic              nxt_valid_s;
    word_t             cur_word_s;
    logic              hs_s;
    logic              last_hs_s;
    logic              cap_s;
    logic              rd_en_s;
    logic [2:0]        occ_s;
    logic [2:0]        occ_after_s;

    assign hs_s      = cur_valid_s & bus.out_ready;
    assign last_hs_s = hs_s & (lane_q == LANE_IDX_W'(LANES - 1));
    assign cap_s     = rd_pend_q[RD_LAT-1];

    // A word finishing its last lane this cycle frees its slot for a new read.
    assign occ_s       = {2'b00, cur_valid_s} + {2'b00, nxt_valid_s}
                       + {1'b0, pend_count(3'(rd_pend_q))};
    assign occ_after_s = occ_s - {2'b00, last_hs_s};
    assign rd_en_s     = rst_n & ~bus.fifo_empty & (occ_after_s < 3'd2);

    assign pend_shift_s = {rd_pend_q, rd_en_s};
    assign rd_pend_d    = pend_shift_s[RD_LAT-1:0];

    // Lane counter advances on every handshake and wraps after the last lane.
    always_comb begin
        lane_d = lane_q;
        if (hs_s) begin
            lane_d = last_hs_s ? LANE_IDX_W'(0) : lane_q + LANE_IDX_W'(1);
        end else begin
            lane_d = lane_q;
        end
    end

    // Lane counter and in-flight read tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q    <= '0;
            rd_pend_q <= '0;
        end else begin
            lane_q    <= lane_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    word_buf2 u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .cap_i       (cap_s),
        .cap_word_i  (bus.fifo_read_dt),
        .pop_i       (last_hs_s),
        .cur_valid_o (cur_valid_s),
        .cur_word_o  (cur_word_s),
        .nxt_valid_o (nxt_valid_s)
    );

    assign bus.fifo_read_en = rd_en_s;
    assign bus.out_valid    = cur_valid_s;
    assign bus.out_data     = cur_word_s[32'(lane_q) * LANE_W +: LANE_W];
    assign bus.out_lane     = lane_q;
    assign bus.out_last     = cur_valid_s & (lane_q == LANE_IDX_W'(LANES - 1));
    assign bus.busy         = cur_valid_s | nxt_valid_s | (|rd_pend_q);

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Directed bench for fifo_read_serializer: FIFO model feeds words, a monitor scores lanes.
module tb_fifo_read_serializer;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ready = 1'b0;
    always #5 clk = ~clk;

    fifo_read_serializer_if bus ();

    fifo_read_serializer #(.RD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    word_t mem [0:63];
    int    wptr = 0;
    int    rptr = 0;
    word_t rd_dt;

    assign bus.fifo_empty   = (wptr == rptr);
    assign bus.fifo_read_dt = rd_dt;
    assign bus.out_ready    = ready;

    // FIFO model with one cycle read latency; restarts with the system reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= 0;
            rd_dt <= '0;
        end else if (bus.fifo_read_en) begin
            rd_dt <= mem[rptr];
            rptr  <= rptr + 1;
        end
    end

    lane_t exp_data [0:511];
    int    exp_lane [0:511];
    int    hs_cyc   [0:511];
    int    rd_cyc   [0:255];
    int    exp_wr = 0;
    int    exp_rd = 0;
    int    cyc = 0;
    int    rd_pulses = 0;
    int    valid_cycles = 0;
    int    total = 0;
    int    bad = 0;

    function automatic lane_t lane_of(input int n, input int k);
        return {8'(n * 16 + k), 16'hAAAA, 40'h0, 8'(n * 16 + k)};
    endfunction

    task automatic push_word(input int n);
        word_t w;
        w = '0;
        for (int k = 0; k < LANES; k++) begin
            w[k*LANE_W +: LANE_W] = lane_of(n, k);
            exp_data[exp_wr] = lane_of(n, k);
            exp_lane[exp_wr] = k;
            exp_wr++;
        end
        mem[wptr] = w;
        wptr++;
    endtask

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_hs(input int target, input int bound);
        int n;
        n = 0;
        while (exp_rd < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("wait_handshakes", 72'(exp_rd >= target), 72'(1));
    endtask

    // Monitor: scores every lane handshake and tallies read pulses.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            exp_rd = exp_wr;
        end else begin
            if (bus.fifo_read_en) begin
                rd_cyc[rd_pulses] = cyc;
                rd_pulses++;
                total++;
                if (bus.fifo_empty) begin
                    bad++;
                    $display("FAIL read_en_while_empty: cycle %0d", cyc);
                end
            end
            if (bus.out_valid) valid_cycles++;
            if (bus.out_valid && ready) begin
                total++;
                if (exp_rd == exp_wr) begin
                    bad++;
                    $display("FAIL unexpected_lane: got data=%h lane=%0d", bus.out_data, bus.out_lane);
                end else begin
                    if (bus.out_data !== exp_data[exp_rd] || bus.out_lane !== 2'(exp_lane[exp_rd])
                        || bus.out_last !== (exp_lane[exp_rd] == LANES - 1)) begin
                        bad++;
                        $display("FAIL lane_%0d: got data=%h lane=%0d last=%b expected data=%h lane=%0d",
                                 exp_rd, bus.out_data, bus.out_lane, bus.out_last,
                                 exp_data[exp_rd], exp_lane[exp_rd]);
                    end
                    hs_cyc[exp_rd] = cyc;
                    exp_rd++;
                end
            end
        end
    end

    initial begin
        int    base;
        int    p0;
        int    v0;
        int    ps;
        lane_t snap_data;
        logic [1:0] snap_lane;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 72'(bus.out_valid), 72'(0));
        chk("rst_out_lane",  72'(bus.out_lane),  72'(0));
        chk("rst_out_last",  72'(bus.out_last),  72'(0));
        chk("rst_busy",      72'(bus.busy),      72'(0));
        chk("rst_out_data",  bus.out_data,       72'(0));
        chk("rst_read_en",   72'(bus.fifo_read_en), 72'(0));
        rst_n = 1'b1;

        // Single word
        @(posedge clk); #1;
        ready = 1'b1;
        base = exp_wr; p0 = rd_pulses;
        push_word(0);
        wait_hs(base + 4, 40);
        repeat (2) @(negedge clk);
        chk("single_reads",   72'(rd_pulses - p0), 72'(1));
        chk("single_latency", 72'(hs_cyc[base] - rd_cyc[p0]), 72'(2));
        chk("single_valid_after", 72'(bus.out_valid), 72'(0));
        chk("single_busy_after",  72'(bus.busy), 72'(0));

        // Empty guard
        p0 = rd_pulses; v0 = valid_cycles;
        repeat (50) begin
            @(posedge clk); #1;
            ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("empty_reads", 72'(rd_pulses - p0), 72'(0));
        chk("empty_valid", 72'(valid_cycles - v0), 72'(0));

        // Back-to-back
        @(posedge clk); #1;
        ready = 1'b1;
        base = exp_wr; p0 = rd_pulses;
        for (int n = 1; n <= 4; n++) push_word(n);
        wait_hs(base + 16, 120);
        chk("b2b_reads",  72'(rd_pulses - p0), 72'(4));
        chk("b2b_no_bubble", 72'(hs_cyc[base + 15] - hs_cyc[base]), 72'(15));

        // Backpressure at lane 1
        @(posedge clk); #1;
        base = exp_wr; p0 = rd_pulses;
        for (int n = 5; n <= 8; n++) push_word(n);
        wait_hs(base + 1, 40);
        @(posedge clk); #1;
        ready = 1'b0;
        @(negedge clk);
        snap_data = bus.out_data; snap_lane = bus.out_lane;
        ps = rd_pulses;
        chk("bp_lane",        72'(snap_lane), 72'(1));
        chk("bp_data",        snap_data, 72'(lane_of(5, 1)));
        chk("bp_reads_before", 72'(rd_pulses - p0), 72'(2));
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold_valid", 72'(bus.out_valid), 72'(1));
            chk("bp_hold_data",  bus.out_data, snap_data);
            chk("bp_hold_lane",  72'(bus.out_lane), 72'(snap_lane));
        end
        chk("bp_no_reads", 72'(rd_pulses - ps), 72'(0));
        chk("bp_busy",     72'(bus.busy), 72'(1));
        @(posedge clk); #1;
        ready = 1'b1;
        wait_hs(base + 16, 120);
        chk("bp_reads_total", 72'(rd_pulses - p0), 72'(4));

        // Edge collision: second word's data lands with the lane-3 handshake
        @(posedge clk); #1;
        base = exp_wr;
        push_word(9);
        wait_hs(base + 2, 40);
        @(posedge clk); #1;
        chk("col_lane2", 72'(bus.out_lane), 72'(2));
        push_word(10);
        wait_hs(base + 8, 60);
        chk("col_no_gap", 72'(hs_cyc[base + 4] - hs_cyc[base + 3]), 72'(1));

        // Reset mid-stream with a read in flight
        @(posedge clk); #1;
        base = exp_wr;
        push_word(11);
        wait_hs(base + 1, 40);
        @(posedge clk); #1;
        push_word(12);
        @(posedge clk); #1;
        chk("rstm_lane2", 72'(bus.out_lane), 72'(2));
        chk("rstm_busy",  72'(bus.busy), 72'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstm_valid", 72'(bus.out_valid), 72'(0));
        chk("rstm_lane",  72'(bus.out_lane), 72'(0));
        chk("rstm_last",  72'(bus.out_last), 72'(0));
        chk("rstm_busy0", 72'(bus.busy), 72'(0));
        chk("rstm_data",  bus.out_data, 72'(0));
        wptr = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rstm_read_en", 72'(bus.fifo_read_en), 72'(0));
        end
        rst_n = 1'b1;
        p0 = rd_pulses; v0 = valid_cycles;
        repeat (10) @(negedge clk);
        chk("post_rst_valid", 72'(valid_cycles - v0), 72'(0));
        chk("post_rst_reads", 72'(rd_pulses - p0), 72'(0));
        @(posedge clk); #1;
        base = exp_wr;
        push_word(13);
        wait_hs(base + 4, 40);
        repeat (2) @(negedge clk);
        chk("final_busy", 72'(bus.busy), 72'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
